innings_controller: RTL and testbench

INNINGS_CONTROLLER -- requirements
Module: innings_controller

---
 rtl/innings_controller.sv | 212 +++++++++++++++++++++
 tb/tb_innings_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/innings_controller.sv
// -----------------------------------------------------------------------------
// innings_controller
// Scoring and sequencing controller for a two-innings limited-overs match.
// Each accepted delivery consumes a 4-bit random outcome code, updates the
// batting team's runs / wickets / ball counters, and produces a one-cycle
// acknowledge. Innings end on all wickets, all legal balls, or (second
// innings) a completed chase; the winner is latched on entering DONE.
//
// Ports
//   clk_fpga      in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-high reset
//   advance       in   1  pulse: IDLE->INN1, BREAK->INN2
//   bowl          in   1  pulse: delivery request
//   lfsr_code     in   4  outcome code, sampled on an accepted bowl
//   state         out  3  IDLE=0, INN1=1, BREAK=2, INN2=3, DONE=4
//   batting_team  out  1  0=team1, 1=team2
//   runs          out  8  runs of the batting team (saturating)
//   wickets       out  4  wickets of the batting team
//   legal_balls   out  7  legal deliveries in the current innings
//   over_num      out  5  completed overs
//   ball_in_over  out  3  legal balls in the current over (0-5)
//   target        out  9  team1 runs + 1 from BREAK onward, else 0
//   last_outcome  out  4  code of the most recent accepted delivery
//   delivery_ack  out  1  pulse in the cycle after an accepted bowl
//   innings_over  out  1  high in BREAK
//   game_over     out  1  high in DONE
//   winner        out  2  00 none, 01 team1, 10 team2, 11 tie
// -----------------------------------------------------------------------------
module innings_controller #(
    parameter int MAX_BALLS = 120,
    parameter int MAX_WKTS  = 10
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic       advance,
    input  logic       bowl,
    input  logic [3:0] lfsr_code,
    output logic [2:0] state,
    output logic       batting_team,
    output logic [7:0] runs,
    output logic [3:0] wickets,
    output logic [6:0] legal_balls,
    output logic [4:0] over_num,
    output logic [2:0] ball_in_over,
    output logic [8:0] target,
    output logic [3:0] last_outcome,
    output logic       delivery_ack,
    output logic       innings_over,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INN1  = 3'd1;
    localparam logic [2:0] ST_BREAK = 3'd2;
    localparam logic [2:0] ST_INN2  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [6:0] BALL_LIMIT = 7'(MAX_BALLS);
    localparam logic [3:0] WKT_LIMIT  = 4'(MAX_WKTS);

    // Outcome decode: {legal, wicket, runs_added[2:0]}.
    function automatic logic [4:0] decode_outcome(input logic [3:0] code);
        logic [4:0] res;
        case (code)
            4'd0, 4'd1, 4'd2:         res = {1'b1, 1'b0, 3'd0};
            4'd3, 4'd4, 4'd5, 4'd6:   res = {1'b1, 1'b0, 3'd1};
            4'd7, 4'd8, 4'd9:         res = {1'b1, 1'b0, 3'd2};
            4'd10:                    res = {1'b1, 1'b0, 3'd3};
            4'd11:                    res = {1'b1, 1'b0, 3'd4};
            4'd12:                    res = {1'b1, 1'b0, 3'd6};
            4'd13, 4'd14:             res = {1'b0, 1'b0, 3'd1};
            4'd15:                    res = {1'b1, 1'b1, 3'd0};
            default:                  res = {1'b1, 1'b0, 3'd0};
        endcase
        return res;
    endfunction

    logic [2:0] next_state;
    logic       accept;
    logic       end_inn1;
    logic       end_inn2;
    logic [1:0] winner_calc;
    logic [4:0] outcome;
    logic [8:0] run_sum;
    logic [7:0] runs_sat;
    logic       limit_hit;
    logic       chase_done;
    logic [8:0] team2_plus1;

    assign outcome     = decode_outcome(lfsr_code);
    assign run_sum     = {1'b0, runs} + {6'd0, outcome[2:0]};
    assign runs_sat    = run_sum[8] ? 8'd255 : run_sum[7:0];
    // Counters are already updated by the time delivery_ack is high, so the
    // end-of-innings tests below look at the post-delivery values.
    assign limit_hit   = (wickets == WKT_LIMIT) || (legal_balls == BALL_LIMIT);
    assign chase_done  = ({1'b0, runs} >= target);
    // Comparing team2+1 against target avoids reconstructing team1's score.
    assign team2_plus1 = {1'b0, runs} + 9'd1;

    // State register with status flags derived from the upcoming state.
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            innings_over <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= next_state;
            innings_over <= (next_state == ST_BREAK);
            game_over    <= (next_state == ST_DONE);
        end
    end

    // Next-state logic; innings end is only judged in the ack cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (advance) next_state = ST_INN1;
                else         next_state = ST_IDLE;
            end
            ST_INN1: begin
                if (delivery_ack && limit_hit) next_state = ST_BREAK;
                else                           next_state = ST_INN1;
            end
            ST_BREAK: begin
                if (advance) next_state = ST_INN2;
                else         next_state = ST_BREAK;
            end
            ST_INN2: begin
                if (delivery_ack && (chase_done || limit_hit)) next_state = ST_DONE;
                else                                           next_state = ST_INN2;
            end
            ST_DONE:  next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Control strobes for the datapath and the winner decision.
    always_comb begin
        accept      = 1'b0;
        end_inn1    = 1'b0;
        end_inn2    = 1'b0;
        winner_calc = 2'b00;
        // A bowl in the ack cycle is dropped so one delivery is in flight.
        if (bowl && !delivery_ack && ((state == ST_INN1) || (state == ST_INN2))) begin
            accept = 1'b1;
        end else begin
            accept = 1'b0;
        end
        end_inn1 = (state == ST_INN1) && (next_state == ST_BREAK);
        end_inn2 = (state == ST_INN2) && (next_state == ST_DONE);
        if (team2_plus1 > target) begin
            winner_calc = 2'b10;
        end else if (team2_plus1 < target) begin
            winner_calc = 2'b01;
        end else begin
            winner_calc = 2'b11;
        end
    end

    // Scoring datapath: delivery updates, innings changeover, winner latch.
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            batting_team <= 1'b0;
            runs         <= 8'd0;
            wickets      <= 4'd0;
            legal_balls  <= 7'd0;
            over_num     <= 5'd0;
            ball_in_over <= 3'd0;
            target       <= 9'd0;
            last_outcome <= 4'd0;
            delivery_ack <= 1'b0;
            winner       <= 2'b00;
        end else begin
            delivery_ack <= accept;
            if (accept) begin
                last_outcome <= lfsr_code;
                runs         <= runs_sat;
                if (outcome[3] && (wickets < WKT_LIMIT)) begin
                    wickets <= wickets + 4'd1;
                end else begin
                    wickets <= wickets;
                end
                if (outcome[4]) begin
                    legal_balls <= legal_balls + 7'd1;
                    if (ball_in_over == 3'd5) begin
                        ball_in_over <= 3'd0;
                        over_num     <= over_num + 5'd1;
                    end else begin
                        ball_in_over <= ball_in_over + 3'd1;
                    end
                end else begin
                    legal_balls <= legal_balls;
                end
            end else if (end_inn1) begin
                target       <= {1'b0, runs} + 9'd1;
                batting_team <= 1'b1;
                runs         <= 8'd0;
                wickets      <= 4'd0;
                legal_balls  <= 7'd0;
                over_num     <= 5'd0;
                ball_in_over <= 3'd0;
            end else if (end_inn2) begin
                winner <= winner_calc;
            end else begin
                winner <= winner;
            end
        end
    end

endmodule

// File: tb/tb_innings_controller.sv
module tb_innings_controller;

    logic       clk_fpga = 1'b0;
    logic       reset;
    logic       advance, bowl, advance6, bowl6;
    logic [3:0] lfsr_code;

    logic [2:0] state, state6;
    logic       batting_team, batting_team6;
    logic [7:0] runs, runs6;
    logic [3:0] wickets, wickets6;
    logic [6:0] legal_balls, legal_balls6;
    logic [4:0] over_num, over_num6;
    logic [2:0] ball_in_over, ball_in_over6;
    logic [8:0] target, target6;
    logic [3:0] last_outcome, last_outcome6;
    logic       delivery_ack, delivery_ack6;
    logic       innings_over, innings_over6;
    logic       game_over, game_over6;
    logic [1:0] winner, winner6;

    innings_controller dut (
        .clk_fpga(clk_fpga), .reset(reset), .advance(advance), .bowl(bowl),
        .lfsr_code(lfsr_code), .state(state), .batting_team(batting_team),
        .runs(runs), .wickets(wickets), .legal_balls(legal_balls),
        .over_num(over_num), .ball_in_over(ball_in_over), .target(target),
        .last_outcome(last_outcome), .delivery_ack(delivery_ack),
        .innings_over(innings_over), .game_over(game_over), .winner(winner)
    );

    innings_controller #(.MAX_BALLS(6), .MAX_WKTS(10)) dut6 (
        .clk_fpga(clk_fpga), .reset(reset), .advance(advance6), .bowl(bowl6),
        .lfsr_code(lfsr_code), .state(state6), .batting_team(batting_team6),
        .runs(runs6), .wickets(wickets6), .legal_balls(legal_balls6),
        .over_num(over_num6), .ball_in_over(ball_in_over6), .target(target6),
        .last_outcome(last_outcome6), .delivery_ack(delivery_ack6),
        .innings_over(innings_over6), .game_over(game_over6), .winner(winner6)
    );

    always #5 clk_fpga = ~clk_fpga;

    typedef struct {
        logic [3:0] last;
        logic [7:0] runs;
        logic [3:0] wk;
        logic [6:0] lb;
        logic [4:0] ov;
        logic [2:0] bio;
    } exp_t;

    typedef struct {
        logic [3:0] code;
        logic [7:0] runs;
        logic [3:0] wk;
        logic [6:0] lb;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] code, input logic [7:0] r,
                            input logic [3:0] wk, input logic [6:0] lb);
        exp_t e;
        int   n;
        n      = int'(lb);
        e.last = code;
        e.runs = r;
        e.wk   = wk;
        e.lb   = lb;
        e.ov   = 5'(n / 6);
        e.bio  = 3'(n % 6);
        sb_q.push_back(e);
    endtask

    // Drive a bowl with its expected post-delivery outputs; returns in the ack cycle.
    task automatic bowl_accept(input logic [3:0] code, input logic [7:0] r,
                               input logic [3:0] wk, input logic [6:0] lb);
        push_exp(code, r, wk, lb);
        lfsr_code = code;
        bowl      = 1'b1;
        tick();
        bowl      = 1'b0;
    endtask

    task automatic bowl_exp(input logic [3:0] code, input logic [7:0] r,
                            input logic [3:0] wk, input logic [6:0] lb);
        bowl_accept(code, r, wk, lb);
        tick();
    endtask

    // Bowl that must not produce an ack (ignored state) or is cut by reset.
    task automatic bowl_raw(input logic [3:0] code);
        lfsr_code = code;
        bowl      = 1'b1;
        tick();
        bowl      = 1'b0;
        tick();
    endtask

    task automatic pulse_adv();
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    task automatic bowl6_once(input logic [3:0] code);
        lfsr_code = code;
        bowl6     = 1'b1;
        tick();
        bowl6     = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Scoreboard: every ack from the main DUT must match the oldest expectation.
    always @(negedge clk_fpga) begin
        if (delivery_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected no delivery");
            end else begin
                sb_e = sb_q.pop_front();
                check("ack_outputs",
                      32'({last_outcome, runs, wickets, legal_balls, over_num, ball_in_over}),
                      32'({sb_e.last, sb_e.runs, sb_e.wk, sb_e.lb, sb_e.ov, sb_e.bio}));
            end
        end
    end

    initial begin
        vecs[0]  = '{4'd3,  8'd1,  4'd0, 7'd1};
        vecs[1]  = '{4'd7,  8'd3,  4'd0, 7'd2};
        vecs[2]  = '{4'd10, 8'd6,  4'd0, 7'd3};
        vecs[3]  = '{4'd13, 8'd7,  4'd0, 7'd3};
        vecs[4]  = '{4'd11, 8'd11, 4'd0, 7'd4};
        vecs[5]  = '{4'd12, 8'd17, 4'd0, 7'd5};
        vecs[6]  = '{4'd0,  8'd17, 4'd0, 7'd6};
        vecs[7]  = '{4'd14, 8'd18, 4'd0, 7'd6};
        vecs[8]  = '{4'd15, 8'd18, 4'd1, 7'd7};
        vecs[9]  = '{4'd2,  8'd18, 4'd1, 7'd8};
        vecs[10] = '{4'd9,  8'd20, 4'd1, 7'd9};
        vecs[11] = '{4'd6,  8'd21, 4'd1, 7'd10};

        reset = 1'b1; advance = 1'b0; bowl = 1'b0;
        advance6 = 1'b0; bowl6 = 1'b0; lfsr_code = 4'd0;
        tick(); tick();
        check("reset_counters", 32'({state, batting_team, runs, wickets, legal_balls, over_num, ball_in_over}), 32'd0);
        check("reset_status", 32'({target, last_outcome, delivery_ack, innings_over, game_over, winner}), 32'd0);
        reset = 1'b0;
        tick();

        // Bowl in IDLE does nothing; advance+bowl together only advances.
        bowl_raw(4'd5);
        check("idle_bowl_ignored", 32'({state, legal_balls, last_outcome}), 32'd0);
        lfsr_code = 4'd3; advance = 1'b1; bowl = 1'b1;
        tick();
        advance = 1'b0; bowl = 1'b0;
        check("adv_with_bowl_state", 32'(state), 32'd1);
        check("adv_with_bowl_no_delivery", 32'({legal_balls, runs, last_outcome}), 32'd0);
        tick();

        // One full over of singles.
        for (int i = 1; i <= 6; i++) bowl_exp(4'd3, 8'(i), 4'd0, 7'(i));
        check("over_runs", 32'(runs), 32'd6);
        check("over_counters", 32'({over_num, ball_in_over, legal_balls}), 32'({5'd1, 3'd0, 7'd6}));
        check("over_acks", 32'(sb_q.size()), 32'd0);
        pulse_adv();
        check("inn1_advance_ignored", 32'(state), 32'd1);

        // Table of every outcome class.
        do_reset();
        pulse_adv();
        for (int i = 0; i < 12; i++) bowl_exp(vecs[i].code, vecs[i].runs, vecs[i].wk, vecs[i].lb);
        check("table_acks", 32'(sb_q.size()), 32'd0);

        // Runs saturate at 255 (43 sixes would be 258).
        do_reset();
        pulse_adv();
        for (int i = 1; i <= 43; i++) bowl_exp(4'd12, (i * 6 > 255) ? 8'd255 : 8'(i * 6), 4'd0, 7'(i));
        check("runs_saturated", 32'(runs), 32'd255);

        // All out in innings 1: BREAK one cycle after the 10th ack.
        do_reset();
        pulse_adv();
        for (int i = 1; i <= 9; i++) bowl_exp(4'd15, 8'd0, 4'(i), 7'(i));
        bowl_accept(4'd15, 8'd0, 4'd10, 7'd10);
        check("inn1_during_last_ack", 32'(state), 32'd1);
        tick();
        check("break_state", 32'({state, innings_over, batting_team}), 32'({3'd2, 1'b1, 1'b1}));
        check("break_target", 32'(target), 32'd1);
        check("break_cleared", 32'({runs, wickets, legal_balls, over_num, ball_in_over}), 32'd0);
        bowl_raw(4'd3);
        check("break_bowl_ignored", 32'({state, legal_balls, runs}), 32'({3'd2, 7'd0, 8'd0}));

        // Reset in the middle of an INN2 ack cycle.
        pulse_adv();
        check("inn2_entered", 32'({state, innings_over}), 32'({3'd3, 1'b0}));
        lfsr_code = 4'd11; bowl = 1'b1;
        tick();
        bowl = 1'b0;
        reset = 1'b1;
        #2;
        check("midack_reset_counters", 32'({state, batting_team, runs, wickets, legal_balls, over_num, ball_in_over}), 32'd0);
        check("midack_reset_status", 32'({target, last_outcome, delivery_ack, innings_over, game_over, winner}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        bowl_raw(4'd3);
        bowl_raw(4'd12);
        check("post_reset_bowls_ignored", 32'({state, legal_balls, runs}), 32'd0);
        pulse_adv();
        check("post_reset_advance", 32'(state), 32'd1);

        // Chase: team1 makes 11 (target 12), team2 gets there with two sixes.
        do_reset();
        pulse_adv();
        bowl_exp(4'd12, 8'd6,  4'd0, 7'd1);
        bowl_exp(4'd11, 8'd10, 4'd0, 7'd2);
        bowl_exp(4'd3,  8'd11, 4'd0, 7'd3);
        for (int i = 1; i <= 10; i++) bowl_exp(4'd15, 8'd11, 4'(i), 7'(3 + i));
        check("chase_target", 32'({state, target}), 32'({3'd2, 9'd12}));
        pulse_adv();
        bowl_exp(4'd12, 8'd6, 4'd0, 7'd1);
        check("chase_not_yet", 32'({state, winner}), 32'({3'd3, 2'b00}));
        bowl_accept(4'd12, 8'd12, 4'd0, 7'd2);
        check("chase_ack_cycle", 32'(state), 32'd3);
        tick();
        check("chase_done", 32'({state, game_over, innings_over, winner, runs}), 32'({3'd4, 1'b1, 1'b0, 2'b10, 8'd12}));
        bowl_raw(4'd12);
        pulse_adv();
        bowl_raw(4'd15);
        check("done_frozen", 32'({state, runs, wickets, legal_balls, winner, last_outcome}),
              32'({3'd4, 8'd12, 4'd0, 7'd2, 2'b10, 4'd12}));

        // Six-ball innings of dots on both sides: tie.
        do_reset();
        advance6 = 1'b1;
        tick();
        advance6 = 1'b0;
        check("short_inn1", 32'(state6), 32'd1);
        lfsr_code = 4'd0; bowl6 = 1'b1;
        tick();
        tick();
        bowl6 = 1'b0;
        check("ack_cycle_bowl_ignored", 32'(legal_balls6), 32'd1);
        tick();
        check("ack_cycle_bowl_still_one", 32'(legal_balls6), 32'd1);
        for (int i = 2; i <= 6; i++) bowl6_once(4'd0);
        check("short_break", 32'({state6, target6}), 32'({3'd2, 9'd1}));
        advance6 = 1'b1;
        tick();
        advance6 = 1'b0;
        for (int i = 1; i <= 6; i++) bowl6_once(4'd0);
        check("short_tie", 32'({state6, game_over6, winner6, legal_balls6, runs6}),
              32'({3'd4, 1'b1, 2'b11, 7'd6, 8'd0}));

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
